// File: rtl/cpu_pkg.sv
// Shared definitions for the sequencer: opcodes, FSM states, instruction fields.
package cpu_pkg;

    // Opcodes 001..101 are forwarded to the ALU unchanged and must match its encoding.
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_INC  = 3'b011;
    localparam logic [2:0] OP_RSH  = 3'b100;
    localparam logic [2:0] OP_LSH  = 3'b101;
    localparam logic [2:0] OP_JZ   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Instruction layout: [15:13] op, [12:8] reserved, [7:0] immediate.
    localparam int INSN_W   = 16;
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 13;
    localparam int RSV_MSB  = 12;
    localparam int RSV_LSB  = 8;
    localparam int IMM_LSB  = 0;

endpackage

// File: rtl/insn_decode.sv
// Combinational instruction field extraction and opcode classification.
module insn_decode
    import cpu_pkg::*;
#(
    parameter int IMM_W = 8
) (
    input  logic [INSN_W-1:0] insn,
    output logic [2:0]        op,
    output logic [IMM_W-1:0]  imm,
    output logic              is_alu,
    output logic              is_jz,
    output logic              is_halt
);

    // Reserved bits carry no meaning; they are deliberately dropped.
    logic unused_rsv;
    assign unused_rsv = ^insn[RSV_MSB:RSV_LSB];

    // Split the word into fields and classify the opcode.
    always_comb begin
        op      = insn[OP_MSB:OP_LSB];
        imm     = insn[IMM_LSB +: IMM_W];
        is_alu  = (op >= OP_ADD) && (op <= OP_LSH);
        is_jz   = (op == OP_JZ);
        is_halt = (op == OP_HALT);
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer driving an external ALU from an accumulator.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INSN_W-1:0] imem_data,
    output logic [2:0]        alu_opcode,
    output logic [IMM_W-1:0]  alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_flag,
    output logic [DATA_W-1:0] acc,
    output logic              zflag,
    output logic              busy,
    output logic              halted
);

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSN_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                zflag_q, zflag_d;
    logic [2:0]          alu_opcode_q, alu_opcode_d;
    logic [IMM_W-1:0]    alu_in1_q, alu_in1_d;
    logic [DATA_W-1:0]   alu_in2_q, alu_in2_d;
    logic                busy_q, busy_d;
    logic                halted_q, halted_d;

    logic [INSN_W-1:0]   dec_src;
    logic [2:0]          dec_op;
    logic [IMM_W-1:0]    dec_imm;
    logic                dec_is_alu, dec_is_jz, dec_is_halt;
    logic [PC_W-1:0]     pc_inc;

    // In DECODE the ROM word is live on imem_data; otherwise look at the latched copy.
    always_comb begin
        dec_src = (state_q == ST_DECODE) ? imem_data : ir_q;
        pc_inc  = pc_q + PC_W'(1);
    end

    insn_decode #(.IMM_W(IMM_W)) u_decode (
        .insn    (dec_src),
        .op      (dec_op),
        .imm     (dec_imm),
        .is_alu  (dec_is_alu),
        .is_jz   (dec_is_jz),
        .is_halt (dec_is_halt)
    );

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        acc_d        = acc_q;
        zflag_d      = zflag_q;
        alu_opcode_d = alu_opcode_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d = imem_data;
                if (dec_is_alu) begin
                    alu_opcode_d = dec_op;
                    alu_in1_d    = dec_imm;
                    alu_in2_d    = acc_q;
                    state_d      = ST_EXEC;
                end else if (dec_is_jz) begin
                    pc_d    = zflag_q ? PC_W'(dec_imm) : pc_inc;
                    state_d = ST_FETCH;
                end else if (dec_is_halt) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                // Flag is taken as-is, so LSH inherits whatever the ALU last produced.
                acc_d        = alu_out;
                zflag_d      = alu_flag;
                pc_d         = pc_inc;
                alu_opcode_d = OP_NOP;
                state_d      = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d   = (state_d == ST_FETCH) || (state_d == ST_DECODE) || (state_d == ST_EXEC);
        halted_d = (state_d == ST_HALT);
    end

    // State and registered outputs; reset clears everything without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            ir_q         <= '0;
            acc_q        <= '0;
            zflag_q      <= 1'b0;
            alu_opcode_q <= OP_NOP;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            acc_q        <= acc_d;
            zflag_q      <= zflag_d;
            alu_opcode_q <= alu_opcode_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
        end
    end

    assign imem_addr  = pc_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_in1    = alu_in1_q;
    assign alu_in2    = alu_in2_q;
    assign acc        = acc_q;
    assign zflag      = zflag_q;
    assign busy       = busy_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: ROM and ALU models plus an instruction-level reference trace.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data = 16'h0000;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_in1;
    logic [15:0] alu_in2;
    logic [15:0] alu_res = 16'h0000;
    logic        alu_flg = 1'b0;
    logic [15:0] acc;
    logic        zflag;
    logic        busy;
    logic        halted;

    int checks = 0;
    int fails  = 0;

    logic [15:0] rom [256];

    typedef struct packed {
        logic        busy;
        logic        halted;
        logic [2:0]  opc;
        logic [7:0]  addr;
        logic [7:0]  in1;
        logic [15:0] in2;
        logic [15:0] acc;
        logic        z;
    } exp_t;

    exp_t expq[$];
    exp_t e;
    int   tcyc = 0;

    cpu_sequencer #(.PC_W(8), .DATA_W(16), .IMM_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .alu_opcode (alu_opcode),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_out    (alu_res),
        .alu_flag   (alu_flg),
        .acc        (acc),
        .zflag      (zflag),
        .busy       (busy),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data appears one clock after the address.
    always @(posedge clk) imem_data <= rom[imem_addr];

    // ALU behaviour: {flag, result}; INC clears the flag, LSH keeps the old one.
    function automatic logic [16:0] alu_fn(input logic [2:0] op, input logic [7:0] in1,
                                           input logic [15:0] in2, input logic oldf);
        logic [15:0] r;
        logic        f;
        r = in2;
        f = oldf;
        case (op)
            3'd1: begin r = in2 + {8'd0, in1}; f = (r == 16'd0); end
            3'd2: begin r = in2 - {8'd0, in1}; f = (r == 16'd0); end
            3'd3: begin r = in2 + 16'd1;       f = 1'b0; end
            3'd4: begin r = in2 >> in1[3:0];   f = (r == 16'd0); end
            3'd5: begin r = in2 << in1[3:0]; end
            default: ;
        endcase
        return {f, r};
    endfunction

    // ALU evaluates on the falling edge and holds when the opcode is 000.
    always @(negedge clk) begin
        if (alu_opcode >= 3'd1 && alu_opcode <= 3'd5)
            {alu_flg, alu_res} <= alu_fn(alu_opcode, alu_in1, alu_in2, alu_flg);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void push_rec(input logic b, input logic h, input logic [2:0] opc,
                                     input logic [7:0] a, input logic [7:0] i1,
                                     input logic [15:0] i2, input logic [15:0] ac, input logic z);
        exp_t r;
        r.busy = b; r.halted = h; r.opc = opc; r.addr = a;
        r.in1 = i1; r.in2 = i2; r.acc = ac; r.z = z;
        expq.push_back(r);
    endfunction

    // Instruction-level reference: expands each executed instruction into its per-cycle outputs.
    task automatic build_trace(input int cap);
        logic [7:0]  pc  = 8'd0;
        logic [7:0]  in1 = 8'd0;
        logic [15:0] in2 = 16'd0;
        logic [15:0] a   = 16'd0;
        logic        z   = 1'b0;
        logic        af;
        logic [15:0] w;
        logic [2:0]  op;
        logic [7:0]  imm;
        logic [16:0] r;
        int          n = 0;
        bit          done = 0;
        af = alu_flg;
        tcyc = 0;
        while (!done && n < cap) begin
            w = rom[pc];
            op = w[15:13];
            imm = w[7:0];
            push_rec(1'b1, 1'b0, 3'd0, pc, in1, in2, a, z);
            push_rec(1'b1, 1'b0, 3'd0, pc, in1, in2, a, z);
            n += 2;
            if (op >= 3'd1 && op <= 3'd5) begin
                in1 = imm;
                in2 = a;
                push_rec(1'b1, 1'b0, op, pc, in1, in2, a, z);
                n++;
                r  = alu_fn(op, imm, a, af);
                a  = r[15:0];
                af = r[16];
                z  = af;
                pc = pc + 8'd1;
            end else if (op == 3'd6) begin
                pc = z ? imm : pc + 8'd1;
            end else if (op == 3'd7) begin
                repeat (3) push_rec(1'b0, 1'b1, 3'd0, pc, in1, in2, a, z);
                done = 1;
            end else begin
                pc = pc + 8'd1;
            end
        end
    endtask

    // Compare process: one expected record per cycle while a trace is pending.
    always @(posedge clk) begin
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk($sformatf("trace[%0d].busy", tcyc),   32'(busy),       32'(e.busy));
            chk($sformatf("trace[%0d].halted", tcyc), 32'(halted),     32'(e.halted));
            chk($sformatf("trace[%0d].opcode", tcyc), 32'(alu_opcode), 32'(e.opc));
            chk($sformatf("trace[%0d].addr", tcyc),   32'(imem_addr),  32'(e.addr));
            chk($sformatf("trace[%0d].in1", tcyc),    32'(alu_in1),    32'(e.in1));
            chk($sformatf("trace[%0d].in2", tcyc),    32'(alu_in2),    32'(e.in2));
            chk($sformatf("trace[%0d].acc", tcyc),    32'(acc),        32'(e.acc));
            chk($sformatf("trace[%0d].zflag", tcyc),  32'(zflag),      32'(e.z));
            tcyc++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".addr"},   32'(imem_addr),  32'd0);
        chk({tag, ".opcode"}, 32'(alu_opcode), 32'd0);
        chk({tag, ".in1"},    32'(alu_in1),    32'd0);
        chk({tag, ".in2"},    32'(alu_in2),    32'd0);
        chk({tag, ".acc"},    32'(acc),        32'd0);
        chk({tag, ".zflag"},  32'(zflag),      32'd0);
        chk({tag, ".busy"},   32'(busy),       32'd0);
        chk({tag, ".halted"}, 32'(halted),     32'd0);
    endtask

    task automatic do_reset(input bit pin);
        @(negedge clk);
        expq.delete();
        start = 1'b0;
        rst = 1'b1;
        #1;
        if (pin) check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    // Start pulse; returns #2 after the posedge that enters FETCH.
    task automatic launch(input int cap);
        @(negedge clk);
        build_trace(cap);
        start = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input int n, input bit rnd);
        repeat (n) begin
            @(negedge clk);
            start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drain(input bit rnd);
        int guard = 0;
        while (expq.size() > 0 && guard < 1000) begin
            cyc(1, rnd);
            guard++;
        end
        chk("drain_timeout", 32'(expq.size()), 32'd0);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_rom();
        do_reset(1);
        cyc(3, 0);
        chk("idle_hold.busy", 32'(busy), 32'd0);
        chk("idle_hold.addr", 32'(imem_addr), 32'd0);

        // ADD 5, SUB 5, JZ 6, HALT at 6; start toggles randomly while running.
        clear_rom();
        rom[0] = 16'h2005; rom[1] = 16'h4005; rom[2] = 16'hC006; rom[6] = 16'hE000;
        launch(40);
        cyc(3, 1);
        chk("p1.acc_after_add", 32'(acc), 32'h5);
        chk("p1.z_after_add", 32'(zflag), 32'd0);
        cyc(3, 1);
        chk("p1.acc_after_sub", 32'(acc), 32'h0);
        chk("p1.z_after_sub", 32'(zflag), 32'd1);
        cyc(2, 1);
        chk("p1.pc_after_jz", 32'(imem_addr), 32'h6);
        cyc(1, 1);
        chk("p1.halted_at_9", 32'(halted), 32'd0);
        cyc(1, 1);
        chk("p1.halted_at_10", 32'(halted), 32'd1);
        chk("p1.busy_at_10", 32'(busy), 32'd0);
        drain(1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        chk("p1.halt_start.halted", 32'(halted), 32'd1);
        chk("p1.halt_start.addr", 32'(imem_addr), 32'h6);
        chk("p1.halt_start.acc", 32'(acc), 32'h0);

        // SUB 1, INC, LSH 0, RSH 0, HALT.
        do_reset(0);
        clear_rom();
        rom[0] = 16'h4001; rom[1] = 16'h6000; rom[2] = 16'hA000; rom[3] = 16'h8000; rom[4] = 16'hE000;
        launch(40);
        cyc(3, 0);
        chk("p2.sub.acc", 32'(acc), 32'hFFFF);
        chk("p2.sub.z", 32'(zflag), 32'd0);
        cyc(3, 0);
        chk("p2.inc.acc", 32'(acc), 32'h0);
        chk("p2.inc.z", 32'(zflag), 32'd0);
        cyc(3, 0);
        chk("p2.lsh.acc", 32'(acc), 32'h0);
        chk("p2.lsh.z", 32'(zflag), 32'd0);
        cyc(3, 0);
        chk("p2.rsh.acc", 32'(acc), 32'h0);
        chk("p2.rsh.z", 32'(zflag), 32'd1);
        drain(0);

        // ADD 1 then JZ not taken.
        do_reset(0);
        clear_rom();
        rom[0] = 16'h2001; rom[1] = 16'hC006; rom[2] = 16'hE000; rom[6] = 16'hE000;
        launch(40);
        cyc(3, 0);
        chk("p3.add.acc", 32'(acc), 32'h1);
        cyc(1, 0);
        chk("p3.jz_fetch.opcode", 32'(alu_opcode), 32'd0);
        cyc(1, 0);
        chk("p3.jz_decode.opcode", 32'(alu_opcode), 32'd0);
        chk("p3.jz_not_taken.addr", 32'(imem_addr), 32'h2);
        drain(0);

        // SUB 0 sets z, JZ to 0xFE, NOPs at 0xFE/0xFF wrap back to 0.
        do_reset(0);
        clear_rom();
        rom[0] = 16'h4000; rom[1] = 16'hC0FE;
        launch(30);
        cyc(5, 0);
        chk("p4.addr_fe", 32'(imem_addr), 32'hFE);
        cyc(2, 0);
        chk("p4.addr_ff", 32'(imem_addr), 32'hFF);
        cyc(2, 0);
        chk("p4.addr_wrap", 32'(imem_addr), 32'h00);
        drain(0);

        // Asynchronous reset while ADD 7 is executing.
        do_reset(0);
        clear_rom();
        rom[0] = 16'h2007; rom[1] = 16'hE000;
        launch(20);
        cyc(2, 0);
        chk("p5.in_exec.opcode", 32'(alu_opcode), 32'd1);
        @(negedge clk);
        #2;
        expq.delete();
        rst = 1'b1;
        #1;
        check_reset_outputs("p5.async_rst");
        @(negedge clk);
        rst = 1'b0;
        launch(20);
        cyc(3, 1);
        chk("p5.resume.acc", 32'(acc), 32'h7);
        drain(1);

        // Random programs with random start activity while running.
        for (int p = 0; p < 8; p++) begin
            do_reset(0);
            for (int i = 0; i < 256; i++) begin
                logic [2:0] op;
                op = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
                rom[i] = {op, 5'($urandom), 8'($urandom)};
            end
            launch(120);
            drain(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
